// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: default geometry and slice helpers for pipelined_adder.
// Latency: n/a (package). Backpressure: n/a.
package pipelined_adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Only equal-width slices are supported.
    function automatic bit split_ok(input int width, input int stages);
        return (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: W-bit ripple adder of per-bit full adders, also exposing the carry into its MSB.
// Latency: combinational. Backpressure: none.
module adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    always_comb begin
        logic c;
        c     = cin;
        sum   = '0;
        c_msb = 1'b0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            if (i == W - 1) c_msb = c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: a+b+cin in STAGES registered slices; subtract mode under PIPELINED_ADDER_SUB_EN.
// Latency: STAGES cycles, one result per cycle.
// Backpressure: all stages freeze while out_valid && !out_ready; in_ready = !out_valid || out_ready.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
        $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

`ifdef PIPELINED_ADDER_SUB_EN
    // Subtraction folds into the add path as a + ~b + 1; cin is ignored.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM  = WIDTH - k * SLICE;
        localparam int DONE = (k + 1) * SLICE;

        logic [REM-1:0]   a_d;
        logic [REM-1:0]   b_d;
        logic             c_d;
        logic             v_d;
        logic [SLICE-1:0] s_slice;
        logic [DONE-1:0]  s_d;
        logic             c_out;
        logic             c_msb;
        logic             v_q;
        logic             c_q;
        logic [DONE-1:0]  s_q;

        if (k == 0) begin : g_src
            assign a_d = a;
            assign b_d = b_eff;
            assign c_d = cin_eff;
            assign v_d = in_valid;
            assign s_d = s_slice;
        end else begin : g_src
            // Upper operand bits arrive via the previous stage's skew registers.
            assign a_d = g_stage[k-1].g_skew.a_q;
            assign b_d = g_stage[k-1].g_skew.b_q;
            assign c_d = g_stage[k-1].c_q;
            assign v_d = g_stage[k-1].v_q;
            assign s_d = {s_slice, g_stage[k-1].s_q};
        end

        adder_slice #(.W(SLICE)) u_slice (
            .a     (a_d[SLICE-1:0]),
            .b     (b_d[SLICE-1:0]),
            .cin   (c_d),
            .sum   (s_slice),
            .cout  (c_out),
            .c_msb (c_msb)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_d;
                c_q <= c_out;
                s_q <= s_d;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [REM-SLICE-1:0] a_q;
            logic [REM-SLICE-1:0] b_q;
            logic                 unused_c_msb;

            assign unused_c_msb = c_msb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d[REM-1:SLICE];
                    b_q <= b_d[REM-1:SLICE];
                end
            end
        end else begin : g_last
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= c_msb ^ c_out;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: vector table plus scoreboard-checked sequences for pipelined_adder.
module tb_pipelined_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int NVEC   = 12;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
`ifdef PIPELINED_ADDER_SUB_EN
    logic             sub;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [33:0] res;
        int          stamp;
    } sb_t;

    vec_t        tbl[NVEC];
    sb_t         sb[$];
    sb_t         ent;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [33:0] exp_cur = '0;
    logic [33:0] held    = '0;
    bit          lat_chk = 1'b0;
    bit          rnd_on  = 1'b0;
    bit          stalled = 1'b0;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference result packed as {cout, ovf, sum}.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] s;
        logic        v;
        s = {1'b0, x} + {1'b0, y} + {32'b0, c};
        v = (x[31] == y[31]) && (s[31] != x[31]);
        return {s[32], v, s[31:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                check({cout, ovf, sum} === held, "hold_stable", {30'b0, cout, ovf, sum}, {30'b0, held});
            if (out_valid && !out_ready)
                check(in_ready === 1'b0, "in_ready_stall", {63'b0, in_ready}, 64'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_out", {30'b0, cout, ovf, sum}, 64'd0);
                end else begin
                    ent = sb.pop_front();
                    check({cout, ovf, sum} === ent.res, "result", {30'b0, cout, ovf, sum}, {30'b0, ent.res});
                    if (lat_chk)
                        check(cyc - ent.stamp == STAGES, "latency", 64'(cyc - ent.stamp), 64'(STAGES));
                end
            end
            stalled = out_valid && !out_ready;
            held    = {cout, ovf, sum};
            if (in_valid && in_ready) sb.push_back('{exp_cur, cyc});
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc, input logic [33:0] te);
        bit ok;
        ok       = 1'b0;
        a        = ta;
        b        = tb_v;
        cin      = tc;
        exp_cur  = te;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(1'b0, "accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        check(sb.size() == 0, "drain", 64'(sb.size()), 64'd0);
        check(out_valid === 1'b0, "no_extra_out", {63'b0, out_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'h0000_000C, 32'h0000_0002, 1'b0, 32'h0000_000E, 1'b0, 1'b0};
        tbl[1]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        tbl[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[4]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[6]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0001, 1'b0, 1'b0};
        tbl[7]  = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
        tbl[8]  = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0, 1'b0};
        tbl[9]  = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        tbl[10] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        check(out_valid === 1'b0, "rst_out_valid", {63'b0, out_valid}, 64'd0);
        check(sum === '0, "rst_sum", {32'b0, sum}, 64'd0);
        check(cout === 1'b0, "rst_cout", {63'b0, cout}, 64'd0);
        check(ovf === 1'b0, "rst_ovf", {63'b0, ovf}, 64'd0);
        check(in_ready === 1'b1, "rst_in_ready", {63'b0, in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back vector table, no stall: every result after exactly STAGES cycles.
        lat_chk = 1'b1;
        for (int i = 0; i < NVEC; i++)
            send(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].cout, tbl[i].ovf, tbl[i].sum});
        drain();

        send(32'd3, 32'd3, 1'b0, {2'b00, 32'd6});
        send(32'd12, 32'd3, 1'b0, {2'b00, 32'd15});
        send(32'd5, 32'd0, 1'b1, {2'b00, 32'd6});
        drain();

        // Consumer stalls for 6 cycles while 8 transactions are offered.
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [31:0] x;
                    logic [31:0] y;
                    x = 32'(i + 1) * 32'h1111_1111;
                    y = 32'hF000_000F + 32'(i);
                    send(x, y, 1'(i & 1), model(x, y, 1'(i & 1)));
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Random operands with random consumer readiness and input gaps.
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1 out_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 30; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            logic        c;
            int          gap;
            x   = $urandom;
            y   = $urandom;
            c   = 1'($urandom_range(0, 1));
            send(x, y, c, model(x, y, c));
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        // Reset with transactions in flight and a result on the output.
        lat_chk = 1'b1;
        for (int i = 0; i < 5; i++)
            send(32'(i + 10), 32'd1, 1'b0, {2'b00, 32'(i + 11)});
        check(out_valid === 1'b1, "pre_reset_valid", {63'b0, out_valid}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check(out_valid === 1'b0, "reset_async_valid", {63'b0, out_valid}, 64'd0);
        check(sum === '0, "reset_async_sum", {32'b0, sum}, 64'd0);
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'd1, 32'd1, 1'b0, {2'b00, 32'd2});
        drain();

`ifdef PIPELINED_ADDER_SUB_EN
        sub = 1'b1;
        send(32'd5, 32'd7, 1'b0, {2'b00, 32'hFFFF_FFFE});
        send(32'd7, 32'd5, 1'b0, {2'b10, 32'h0000_0002});
        send(32'h8000_0000, 32'd1, 1'b1, {2'b11, 32'h7FFF_FFFF});
        sub = 1'b0;
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the 32-bit ripple-carry adder.
- Splits a WIDTH-bit addition into STAGES equal carry-chain slices, with one slice registered per pipeline stage, so the clock rate is set by the slice width rather than by WIDTH.
- Uses a valid/ready handshake on both sides and supports full backpressure.
- Sits between operand sources and any datapath consumer that needs sum, carry and signed overflow.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; slice width SLICE = WIDTH/STAGES; STAGES >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block accepts the transaction this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in of the transaction.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow: the MSB carry-in differs from the MSB carry-out.

Behaviour:
- Reset (asynchronous assert, synchronous release): all stage valid bits = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0. in_ready is combinational and therefore reads 1 during reset.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. When adv = 0, every stage register holds.
- Accept: when in_valid && in_ready, the transaction enters stage 0 on the next edge.
- Stage k (0..STAGES-1):
  - Adds bits [k*SLICE +: SLICE] of a and b plus the carry from stage k-1 (stage 0 uses cin).
  - Registers the partial sum slice, the carry out, and the valid bit.
  - Carries the not-yet-added upper operand slices forward (skew registers).
  - Carries the already-produced lower sum slices forward (deskew registers).
- Latency: exactly STAGES cycles from acceptance to out_valid, with no stall.
- Throughput: one result per cycle with no stall.
- Bubbles: a cycle with in_valid = 0 and adv = 1 inserts valid = 0 into stage 0; bubbles flow downstream and never generate out_valid.
- Results leave in acceptance order. No transaction is lost or duplicated under any out_ready pattern.
- Output stability: while out_valid && !out_ready, sum, cout and ovf hold stable.
- Output values: cout = final-stage carry. ovf = carry into bit WIDTH-1 XOR cout; the final stage exposes both carries.
- Wrap-around: a sum of 2^WIDTH or more wraps modulo 2^WIDTH, with cout = 1.
- Simultaneous accept and drain in the same cycle is legal; the occupancy stays constant.
- Reset mid-operation: all in-flight transactions are discarded and out_valid drops immediately (asynchronously).
- STAGES = 1 degenerates to a single registered ripple adder with latency 1.

Optional Feature:
- Macro: PIPELINED_ADDER_SUB_EN.
- With the macro defined:
  - Extra input sub (1 bit), sampled with a and b.
  - sub = 1: computes a - b as a + ~b + 1, ignoring cin. cout = 1 means no borrow. ovf is the signed subtraction overflow.
  - sub = 0: identical to the base behaviour.
- Without the macro: the sub port does not exist and the logic is add-only.

Decomposition:
- Package pipelined_adder_pkg:
  - Default-width constants.
  - Function computing SLICE.
  - Elaboration check that WIDTH % STAGES == 0.
- Sub-module adder_slice:
  - Combinational SLICE-bit ripple adder made of per-bit full adders.
  - Outputs the slice sum, the carry out, and the carry into the slice MSB.
  - Instantiated STAGES times in a generate loop; the pipeline registers live in pipelined_adder.

Test Plan:
- Basic: a=32'hC, b=32'h2, cin=0, out_ready=1 -> after 4 cycles out_valid=1, sum=32'hE, cout=0, ovf=0.
- Carry across slices: a=32'h0000_00FF, b=32'h0000_0001 -> sum=32'h0000_0100. a=32'hFFFF_FFFF, b=32'h1 -> sum=0, cout=1, ovf=0.
- Signed overflow: a=32'h7FFF_FFFF, b=32'h1 -> sum=32'h8000_0000, cout=0, ovf=1.
- Back-to-back: 3+3, then 12+3, then 5+cin=1 on consecutive cycles -> outputs 6, 15, 6 on consecutive cycles from cycle 4.
- Backpressure: hold out_ready=0 for 6 cycles while driving 8 transactions -> in_ready drops once out_valid=1; all 8 results emerge in order with no loss; sum is stable while stalled.
- Reset mid-flight: assert rst_n=0 with 3 in flight -> out_valid=0 immediately; after release, the first new transaction 1+1 yields 2 after 4 cycles. With PIPELINED_ADDER_SUB_EN: sub=1, a=5, b=7 -> sum=32'hFFFF_FFFE, cout=0.
